sram_fsm_ctrl: RTL and testbench
================================

Name: sram_fsm_ctrl

Overview:
Parametrised single-port SRAM with an integrated access FSM. It is the next generation of the 8x8 bitcell SRAM-with-FSM block, generalised in data width and depth. It adds a ready/valid handshake, back-to-back access, per-word "written" tracking with an error flag, and an optional post-reset clear sweep. It sits between a simple request master (op/select) and the bitcell array model.

Parameters:
DATA_W, 8, word width in bits (>=1)
ADDR_W, 3, address width; DEPTH = 2**ADDR_W words (localparam, not overridable)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
op  in  1  request type: 1 = write, 0 = read
select  in  1  request strobe; sampled only when ready=1
adr  in  ADDR_W  request word address
in  in  DATA_W  write data
ready  out  1  FSM can accept a request this cycle
valid  out  1  one-cycle completion pulse
rw  out  1  type of last accepted request (1 = write)
err  out  1  completed read hit a never-written word; qualified by valid
state  out  3  current FSM state encoding
out  out  DATA_W  read data; holds until the next completed read

Behaviour:
- Reset (async assert, sync release): state=IDLE, out=0, valid=0, rw=0, err=0, all written flags=0. Array contents are not reset.
- State encodings (low 2 bits are compatible with the legacy AB outputs): IDLE 3'b011, WRITE 3'b001, READ 3'b010, HOLD 3'b000, CLEAR 3'b100.
- ready = (state==IDLE || state==HOLD); this is combinational from the state register.
- Accept: at a posedge with ready=1 and select=1, register adr_q/din_q/op_q and set rw<=op. Next state is WRITE if op=1, else READ. With select=0: IDLE stays IDLE, HOLD goes to IDLE.
- WRITE (one cycle): at the next edge mem[adr_q]<=din_q, written[adr_q]<=1, valid<=1, err<=0, go to HOLD. out is unchanged.
- READ (one cycle): at the next edge out<=mem[adr_q], err<=~written[adr_q], valid<=1, go to HOLD.
- valid is high for exactly the one cycle spent in HOLD following WRITE/READ, and is otherwise 0. err is meaningful only while valid=1 and is cleared with valid.
- Latency: accept edge N -> completion edge N+1 -> valid high from N+1 to N+2. A new request can be accepted at N+2 (from HOLD), giving a maximum throughput of one access per 2 cycles.
- Back-to-back: select held high with op=0 performs repeated reads of adr (alternating READ/HOLD). valid pulses every second cycle.
- op, adr and in are ignored while ready=0. There is no queueing.
- Reset asserted during WRITE: the write is aborted and mem/written are unmodified.
- All addresses 0..DEPTH-1 are legal. There is no out-of-range case.
- The CLEAR state is reachable only with the optional feature enabled.

Optional Feature:
Macro SRAM_INIT_CLEAR_EN.
- Defined:
  - On reset, state=CLEAR and an internal counter clr_adr=0.
  - Each CLEAR cycle writes mem[clr_adr]<=0, sets written[clr_adr]<=1 and increments clr_adr.
  - After the write to DEPTH-1, go to IDLE. CLEAR lasts DEPTH cycles after reset release.
  - ready=0, valid=0 and out=0 throughout.
  - Reads then never set err.
  - Reset during CLEAR restarts the sweep at address 0.
- Not defined: the CLEAR state and its counter are absent, the reset state is IDLE, and unwritten words read as X with err=1.

Test Plan:
1. Reset, hold op=0/select=0 for 3 cycles -> state=011, ready=1, valid=0, out=0, rw=0.
2. Write 8'h55 to adr 0 (op=1/select=1 for one cycle), then read adr 0 -> WRITE pulse: state 001, then valid=1 with rw=1, err=0. Read: state 010, then valid=1, out=8'h55, err=0.
3. Write 8'hA5 to 7 and 8'h3C to 3, then hold select=1/op=0/adr=7 for 8 cycles -> valid toggles 1 every second cycle, out=8'hA5 constant, ready alternates.
4. Read unwritten adr 5 (no SRAM_INIT_CLEAR_EN) -> valid=1, err=1. Repeat with the macro defined -> the first 8 cycles after reset have state=100 and ready=0; the read then returns out=0, err=0.
5. Assert rst_n=0 while in WRITE of 8'hFF to adr 2, then read adr 2 -> err=1 (or out=0 with the macro defined), confirming the write was aborted; all outputs were at reset values during reset.
6. Pulse select=1 with op=1 during a WRITE/READ cycle (ready=0) -> request ignored; rw and adr_q are unchanged, and the next valid reflects the original request only.

Source files
------------

// File: rtl/sram_fsm_ctrl_if.sv
// ============================================================================
// sram_fsm_ctrl_if : request/response bundle between a master and sram_fsm_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

interface sram_fsm_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              op;
    logic              select;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] in;
    logic              ready;
    logic              valid;
    logic              rw;
    logic              err;
    logic [2:0]        state;
    logic [DATA_W-1:0] out;

    modport master (
        output op, select, adr, in,
        input  ready, valid, rw, err, state, out
    );

    modport slave (
        input  op, select, adr, in,
        output ready, valid, rw, err, state, out
    );
endinterface

`default_nettype wire

// File: rtl/sram_fsm_ctrl.sv
// ============================================================================
// sram_fsm_ctrl : single-port SRAM with access FSM, written tracking and an
//                 optional post-reset clear sweep (macro SRAM_INIT_CLEAR_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_fsm_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    sram_fsm_ctrl_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;

    // Low two bits match the legacy AB state outputs.
    typedef enum logic [2:0] {
        ST_HOLD  = 3'b000,
        ST_WRITE = 3'b001,
        ST_READ  = 3'b010,
        ST_IDLE  = 3'b011,
        ST_CLEAR = 3'b100
    } state_t;

`ifdef SRAM_INIT_CLEAR_EN
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    localparam state_t RESET_STATE = ST_IDLE;
`endif

    state_t             state_q,   state_d;
    logic [ADDR_W-1:0]  adr_q,     adr_d;
    logic [DATA_W-1:0]  din_q,     din_d;
    logic [DATA_W-1:0]  out_q,     out_d;
    logic               valid_q,   valid_d;
    logic               rw_q,      rw_d;
    logic               err_q,     err_d;
    logic [DEPTH-1:0]   written_q, written_d;
`ifdef SRAM_INIT_CLEAR_EN
    logic [ADDR_W-1:0]  clr_adr_q, clr_adr_d;
`endif

    logic               mem_we;
    logic [ADDR_W-1:0]  mem_wadr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem [DEPTH];

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        din_d     = din_q;
        out_d     = out_q;
        valid_d   = 1'b0;
        rw_d      = rw_q;
        err_d     = 1'b0;
        written_d = written_q;
        mem_we    = 1'b0;
        mem_wadr  = adr_q;
        mem_wdata = din_q;
`ifdef SRAM_INIT_CLEAR_EN
        clr_adr_d = clr_adr_q;
`endif
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (bus.select) begin
                    adr_d   = bus.adr;
                    din_d   = bus.in;
                    rw_d    = bus.op;
                    state_d = bus.op ? ST_WRITE : ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                mem_we            = 1'b1;
                written_d[adr_q]  = 1'b1;
                valid_d           = 1'b1;
                state_d           = ST_HOLD;
            end
            ST_READ: begin
                out_d   = mem[adr_q];
                err_d   = ~written_q[adr_q];
                valid_d = 1'b1;
                state_d = ST_HOLD;
            end
`ifdef SRAM_INIT_CLEAR_EN
            ST_CLEAR: begin
                mem_we               = 1'b1;
                mem_wadr             = clr_adr_q;
                mem_wdata            = '0;
                written_d[clr_adr_q] = 1'b1;
                clr_adr_d            = clr_adr_q + ADDR_W'(1);
                if (clr_adr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RESET_STATE;
            adr_q     <= '0;
            din_q     <= '0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            rw_q      <= 1'b0;
            err_q     <= 1'b0;
            written_q <= '0;
`ifdef SRAM_INIT_CLEAR_EN
            clr_adr_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            din_q     <= din_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            rw_q      <= rw_d;
            err_q     <= err_d;
            written_q <= written_d;
`ifdef SRAM_INIT_CLEAR_EN
            clr_adr_q <= clr_adr_d;
`endif
        end
    end

    // Array is not reset; an async reset forces the state away from WRITE,
    // so a write in flight is dropped.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wadr] <= mem_wdata;
        end
    end

    assign bus.ready = (state_q == ST_IDLE) || (state_q == ST_HOLD);
    assign bus.valid = valid_q;
    assign bus.rw    = rw_q;
    assign bus.err   = err_q;
    assign bus.state = state_q;
    assign bus.out   = out_q;

endmodule

`default_nettype wire

// File: tb/tb_sram_fsm_ctrl.sv
// ============================================================================
// tb_sram_fsm_ctrl : vector table, directed corner sequences and random
//                    accesses checked against a transaction-level SRAM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_sram_fsm_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    int checks = 0;
    int errors = 0;

    sram_fsm_ctrl_if #(.DATA_W(8), .ADDR_W(3)) bus ();

    sram_fsm_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: contents, written flags, last read data.
    logic [7:0] ref_mem     [8];
    bit         ref_known   [8];
    bit         ref_written [8];
    logic [7:0] ref_out;
    bit         ref_out_known;

    typedef struct {
        logic       op;
        logic [2:0] adr;
        logic [7:0] din;
        logic [7:0] exp_out;
        logic       exp_err;
        bit         chk_out;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_reset_outputs();
`ifdef SRAM_INIT_CLEAR_EN
        chk("rst_state", 32'(bus.state), 32'h4);
        chk("rst_ready", 32'(bus.ready), 32'h0);
`else
        chk("rst_state", 32'(bus.state), 32'h3);
        chk("rst_ready", 32'(bus.ready), 32'h1);
`endif
        chk("rst_valid", 32'(bus.valid), 32'h0);
        chk("rst_rw",    32'(bus.rw),    32'h0);
        chk("rst_err",   32'(bus.err),   32'h0);
        chk("rst_out",   32'(bus.out),   32'h0);
    endtask

    // Assert reset shortly after an edge, hold it, release it mid-cycle.
    task automatic do_reset();
        bus.select = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) ref_written[i] = 1'b0;
        ref_out       = 8'h00;
        ref_out_known = 1'b1;
`ifdef SRAM_INIT_CLEAR_EN
        for (int i = 0; i < 8; i++) begin
            chk("clr_state", 32'(bus.state), 32'h4);
            chk("clr_ready", 32'(bus.ready), 32'h0);
            chk("clr_valid", 32'(bus.valid), 32'h0);
            chk("clr_out",   32'(bus.out),   32'h0);
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 8; i++) begin
            ref_mem[i]     = 8'h00;
            ref_known[i]   = 1'b1;
            ref_written[i] = 1'b1;
        end
`endif
        chk("post_rst_state", 32'(bus.state), 32'h3);
    endtask

    task automatic idle(input int n);
        bus.select = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.op  = 1'($urandom_range(0, 1));
            bus.adr = 3'($urandom_range(0, 7));
            bus.in  = 8'($urandom);
            @(posedge clk);
            #1;
            chk("idle_state", 32'(bus.state), 32'h3);
            chk("idle_ready", 32'(bus.ready), 32'h1);
            chk("idle_valid", 32'(bus.valid), 32'h0);
            chk("idle_err",   32'(bus.err),   32'h0);
            if (ref_out_known) chk("idle_out", 32'(bus.out), 32'(ref_out));
        end
    endtask

    // One request from a ready state; during the busy cycle a conflicting
    // request is presented, which must be ignored.
    task automatic access(input logic o, input logic [2:0] a, input logic [7:0] d,
                          input logic [7:0] eo, input logic ee, input bit co);
        chk("req_ready", 32'(bus.ready), 32'h1);
        bus.op = o; bus.select = 1'b1; bus.adr = a; bus.in = d;
        @(posedge clk);
        #1;
        chk("busy_state", 32'(bus.state), o ? 32'h1 : 32'h2);
        chk("busy_ready", 32'(bus.ready), 32'h0);
        chk("busy_valid", 32'(bus.valid), 32'h0);
        chk("busy_rw",    32'(bus.rw),    32'(o));
        bus.op     = ~o;
        bus.adr    = a + 3'd1 + 3'($urandom_range(0, 6));
        bus.in     = 8'($urandom);
        bus.select = 1'b1;
        @(posedge clk);
        #1;
        bus.select = 1'b0;
        chk("done_state", 32'(bus.state), 32'h0);
        chk("done_ready", 32'(bus.ready), 32'h1);
        chk("done_valid", 32'(bus.valid), 32'h1);
        chk("done_rw",    32'(bus.rw),    32'(o));
        chk("done_err",   32'(bus.err),   32'(ee));
        if (co) chk("done_out", 32'(bus.out), 32'(eo));
        if (o) begin
            ref_mem[a]     = d;
            ref_known[a]   = 1'b1;
            ref_written[a] = 1'b1;
        end else begin
            ref_out       = ref_mem[a];
            ref_out_known = ref_known[a];
        end
    endtask

    task automatic model_access(input logic o, input logic [2:0] a, input logic [7:0] d);
        if (o) access(o, a, d, ref_out, 1'b0, ref_out_known);
        else   access(o, a, d, ref_mem[a], ~ref_written[a], ref_known[a]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            ref_mem[i] = 8'hxx; ref_known[i] = 1'b0; ref_written[i] = 1'b0;
        end
        vecs[0] = '{1'b1, 3'd0, 8'h55, 8'h00, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 3'd0, 8'h00, 8'h55, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 3'd7, 8'hA5, 8'h55, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 3'd3, 8'h3C, 8'h55, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 3'd3, 8'h00, 8'h3C, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 3'd7, 8'h00, 8'hA5, 1'b0, 1'b1};
`ifdef SRAM_INIT_CLEAR_EN
        vecs[6] = '{1'b0, 3'd5, 8'h00, 8'h00, 1'b0, 1'b1};
`else
        vecs[6] = '{1'b0, 3'd5, 8'h00, 8'h00, 1'b1, 1'b0};
`endif
        bus.op = 1'b0; bus.select = 1'b0; bus.adr = '0; bus.in = '0;

        #3;
        do_reset();
        idle(3);

        for (int i = 0; i < 7; i++) begin
            access(vecs[i].op, vecs[i].adr, vecs[i].din,
                   vecs[i].exp_out, vecs[i].exp_err, vecs[i].chk_out);
            if (i % 2 == 1) idle(1);
        end
        idle(1);

        // Back-to-back reads of address 7 with select held high.
        bus.op = 1'b0; bus.adr = 3'd7; bus.select = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("b2b_valid", 32'(bus.valid), 32'(i % 2));
            chk("b2b_ready", 32'(bus.ready), 32'(i % 2));
            if (i % 2 == 1) chk("b2b_out", 32'(bus.out), 32'hA5);
        end
        bus.select = 1'b0;
        ref_out = 8'hA5; ref_out_known = 1'b1;
        idle(1);

        // Reset during a write: the old content of address 2 must survive.
        model_access(1'b1, 3'd2, 8'h11);
        idle(1);
        bus.op = 1'b1; bus.adr = 3'd2; bus.in = 8'hFF; bus.select = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_wr_state", 32'(bus.state), 32'h1);
        do_reset();
        model_access(1'b0, 3'd2, 8'h00);
`ifdef SRAM_INIT_CLEAR_EN
        chk("abort_out", 32'(bus.out), 32'h00);
`else
        chk("abort_err", 32'(bus.err), 32'h1);
        chk("abort_out", 32'(bus.out), 32'h11);
`endif
        idle(1);

        // Random traffic against the model, with occasional resets.
        for (int n = 0; n < 300; n++) begin
            logic       o;
            logic [2:0] a;
            logic [7:0] d;
            o = 1'($urandom_range(0, 1));
            a = 3'($urandom_range(0, 7));
            d = 8'($urandom);
            model_access(o, a, d);
            if (n % 97 == 96) do_reset();
            else idle($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
